serial_relational_op: RTL and testbench
=======================================

# serial_relational_op

Bit-serial relational comparator that takes two WIDTH-bit operands as a stream of bit pairs, MSB first. It produces the same eight relational flags as the team's parallel comparator: eq, neq, ceq, cneq, lt, gt, lte, gte. It is the receiving end of the serialised operand path, used where operands arrive one bit per transfer rather than as parallel buses. It uses a small FSM, a bit counter and sticky decision registers, with a valid/ready handshake on the bit stream.

## Interface
- WIDTH, default 4: operand width in bits; minimum 2.
- clk  input  1  clock; single clock domain, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a comparison; sampled only in IDLE.
- bit_valid  input  1  a_bit/b_bit hold a valid bit pair.
- a_bit  input  1  current bit of operand a, MSB first.
- b_bit  input  1  current bit of operand b, MSB first.
- bit_ready  output  1  block accepts a bit pair this cycle.
- busy  output  1  a comparison is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse; flags are valid from this cycle.
- eq, neq, ceq, cneq, lt, gt, lte, gte  output  1 each  registered relational flags.

## Operation
- FSM states:
  - IDLE: bit_ready=0, busy=0. If start=1, go to SHIFT. Clear mismatch, decided, a_gt and ce_mis. Load bit counter with WIDTH-1.
  - SHIFT: bit_ready=1, busy=1.
    - A transfer happens when bit_valid && bit_ready.
    - If decided=0 and a_bit!=b_bit: set decided=1, mismatch=1, a_gt=a_bit.
    - If a_bit!==b_bit, set ce_mis=1. This is sticky, 4-state case-inequality.
    - The counter decrements on each transfer. A transfer with counter==0 moves to DONE.
  - DONE: busy=1, bit_ready=0.
    - Flag registers load: eq=~mismatch, neq=mismatch, ceq=~ce_mis, cneq=ce_mis.
    - Ordering flags: gt=mismatch&a_gt, lt=mismatch&~a_gt, gte=~lt, lte=~gt.
    - done=1 for this one cycle. Next state is IDLE unconditionally.
- No transfer when bit_valid=0: state, counter and registers hold. The block stalls indefinitely.
- start outside IDLE is ignored. start and done in the same cycle is not possible, because DONE always exits to IDLE.
- Flags hold their last result until the next DONE. They do not change during SHIFT.
- The block never terminates early: it always consumes exactly WIDTH transfers, even when the result is decided at the MSB.
- For 0/1 inputs, ceq==eq and cneq==neq. They differ only in simulation when X/Z bits appear.

## Timing
- Reset (async assert, sync release): state=IDLE. bit_ready, busy, done and all eight flags are 0. Counter and sticky registers are 0.
- Reset mid-comparison: abort immediately. No done pulse. Flags return to 0.
- Latency with bit_valid held high: start in cycle 0, bits accepted in cycles 1..WIDTH, done and new flags in cycle WIDTH+1. IDLE in cycle WIDTH+2.
- Back-to-back comparisons: the earliest next start is in cycle WIDTH+2. Minimum period is WIDTH+2 cycles.
- bit_ready is a registered function of state only. It never depends combinationally on bit_valid.

## Configuration
- SERIAL_REL_SIGNED_CMP_EN
  - Defined: operands are two's complement. If the first (MSB) bit pair differs, a_gt=b_bit, so a negative a is less. All later bits use a_gt=a_bit.
  - Undefined: unsigned comparison only. a_gt=a_bit at every bit position. No sign logic is synthesised.
  - eq, neq, ceq and cneq are unaffected by the macro.

## Structure
- Package serial_rel_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - a flag index constants set (EQ..GTE), for bench checking.
- Sub-module rel_flag_decode: combinational. Maps (mismatch, a_gt, ce_mis) to the eight flag values. The top level registers its outputs in DONE.

## Test plan
- Unsigned, WIDTH=4, a=9 (1001), b=9, bit_valid held high: done in cycle 5 with eq=ceq=lte=gte=1 and the other flags 0.
- a=3 (0011), b=12 (1100): lt=neq=cneq=lte=1; eq=gt=gte=ceq=0. The decision is taken at the MSB, but done still comes in cycle 5.
- a=9 (1001), b=3 (0011): gt=1 with the macro undefined. With SERIAL_REL_SIGNED_CMP_EN defined (a=-7, b=3): lt=1, gt=0.
- bit_valid low for 3 cycles after the second bit: bit_ready stays 1 and no state advances. done arrives 3 cycles late with the correct flags.
- Pulse start during SHIFT: ignored, no extra transfer consumed. Then drive rst_n=0 after 2 bits: busy, done and the flags drop to 0 immediately, and no done pulse occurs.

Source files
------------

// File: rtl/serial_rel_pkg.sv
// Shared types for the bit-serial relational comparator: FSM state encoding
// and the bit positions of the eight relational flags in a packed flag vector.
package serial_rel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_FLAGS = 8;

    // Flag bit positions within a logic [NUM_FLAGS-1:0] vector.
    localparam int FLAG_EQ   = 0;
    localparam int FLAG_NEQ  = 1;
    localparam int FLAG_CEQ  = 2;
    localparam int FLAG_CNEQ = 3;
    localparam int FLAG_LT   = 4;
    localparam int FLAG_GT   = 5;
    localparam int FLAG_LTE  = 6;
    localparam int FLAG_GTE  = 7;

endpackage

// File: rtl/rel_flag_decode.sv
// Combinational mapping of the comparator's sticky decision bits
// (mismatch, a_gt, ce_mis) to the eight relational flag values.
module rel_flag_decode
    import serial_rel_pkg::*;
(
    input  logic                 mismatch,
    input  logic                 a_gt,
    input  logic                 ce_mis,
    output logic [NUM_FLAGS-1:0] flags
);

    logic lt;
    logic gt;

    always_comb begin
        gt = mismatch & a_gt;
        lt = mismatch & ~a_gt;

        flags            = '0;
        flags[FLAG_EQ]   = ~mismatch;
        flags[FLAG_NEQ]  = mismatch;
        flags[FLAG_CEQ]  = ~ce_mis;
        flags[FLAG_CNEQ] = ce_mis;
        flags[FLAG_LT]   = lt;
        flags[FLAG_GT]   = gt;
        flags[FLAG_LTE]  = ~gt;
        flags[FLAG_GTE]  = ~lt;
    end

endmodule

// File: rtl/serial_relational_op.sv
// Bit-serial MSB-first relational comparator with valid/ready bit stream.
// Define SERIAL_REL_SIGNED_CMP_EN for two's-complement operand ordering.
module serial_relational_op
    import serial_rel_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   bit_valid,
    input  logic   a_bit,
    input  logic   b_bit,
    output logic   bit_ready,
    output logic   busy,
    output logic   done,
    output logic   eq,
    output logic   neq,
    output logic   ceq,
    output logic   cneq,
    output logic   lt,
    output logic   gt,
    output logic   lte,
    output logic   gte,
    output state_t dbg_state
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: a bit pair is consumed on a rising edge where bit_valid and
    // bit_ready are both high; bit_ready is registered and depends only on
    // state, and the sender must hold a_bit/b_bit stable while bit_valid=1.

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 mismatch, decided, a_gt, ce_mis;
    logic                 mismatch_n, decided_n, a_gt_n, ce_mis_n;
    logic [NUM_FLAGS-1:0] flag_q;
    logic [NUM_FLAGS-1:0] flag_d;
    logic                 xfer;

    assign xfer = bit_valid && bit_ready;

    // Next sticky values are decoded directly so flags are ready in DONE.
    always_comb begin
        mismatch_n = mismatch;
        decided_n  = decided;
        a_gt_n     = a_gt;
        ce_mis_n   = ce_mis;
        if (xfer) begin
            if (!decided && (a_bit != b_bit)) begin
                decided_n  = 1'b1;
                mismatch_n = 1'b1;
`ifdef SERIAL_REL_SIGNED_CMP_EN
                // Sign bit: a set sign in a means a is the smaller operand.
                a_gt_n = (cnt == CW'(WIDTH - 1)) ? b_bit : a_bit;
`else
                a_gt_n = a_bit;
`endif
            end
            if (a_bit !== b_bit) begin
                ce_mis_n = 1'b1;
            end
        end
    end

    rel_flag_decode u_decode (
        .mismatch (mismatch_n),
        .a_gt     (a_gt_n),
        .ce_mis   (ce_mis_n),
        .flags    (flag_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mismatch  <= 1'b0;
            decided   <= 1'b0;
            a_gt      <= 1'b0;
            ce_mis    <= 1'b0;
            bit_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            flag_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        bit_ready <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= CW'(WIDTH - 1);
                        mismatch  <= 1'b0;
                        decided   <= 1'b0;
                        a_gt      <= 1'b0;
                        ce_mis    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        cnt      <= cnt - 1'b1;
                        mismatch <= mismatch_n;
                        decided  <= decided_n;
                        a_gt     <= a_gt_n;
                        ce_mis   <= ce_mis_n;
                        if (cnt == '0) begin
                            state     <= DONE;
                            bit_ready <= 1'b0;
                            done      <= 1'b1;
                            flag_q    <= flag_d;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    bit_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign eq        = flag_q[FLAG_EQ];
    assign neq       = flag_q[FLAG_NEQ];
    assign ceq       = flag_q[FLAG_CEQ];
    assign cneq      = flag_q[FLAG_CNEQ];
    assign lt        = flag_q[FLAG_LT];
    assign gt        = flag_q[FLAG_GT];
    assign lte       = flag_q[FLAG_LTE];
    assign gte       = flag_q[FLAG_GTE];
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_relational_op.sv
// Scoreboard bench for serial_relational_op: directed operand pairs with
// hand-computed flags; a monitor checks flags and done timing on each done.
module tb_serial_relational_op;
    import serial_rel_pkg::*;

    localparam int WIDTH = 4;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   start = 1'b0;
    logic   bit_valid = 1'b0;
    logic   a_bit = 1'b0;
    logic   b_bit = 1'b0;
    logic   bit_ready, busy, done;
    logic   eq, neq, ceq, cneq, lt, gt, lte, gte;
    state_t dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];

    serial_relational_op #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .neq       (neq),
        .ceq       (ceq),
        .cneq      (cneq),
        .lt        (lt),
        .gt        (gt),
        .lte       (lte),
        .gte       (gte),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dut_flags();
        logic [7:0] f;
        f = '0;
        f[FLAG_EQ]   = eq;
        f[FLAG_NEQ]  = neq;
        f[FLAG_CEQ]  = ceq;
        f[FLAG_CNEQ] = cneq;
        f[FLAG_LT]   = lt;
        f[FLAG_GT]   = gt;
        f[FLAG_LTE]  = lte;
        f[FLAG_GTE]  = gte;
        return f;
    endfunction

    // Expected flag vector from individually listed flag values.
    function automatic logic [7:0] mk(input bit e, input bit ne, input bit ce, input bit cne,
                                      input bit l, input bit g, input bit le, input bit ge);
        logic [7:0] f;
        f = '0;
        f[FLAG_EQ]   = e;
        f[FLAG_NEQ]  = ne;
        f[FLAG_CEQ]  = ce;
        f[FLAG_CNEQ] = cne;
        f[FLAG_LT]   = l;
        f[FLAG_GT]   = g;
        f[FLAG_LTE]  = le;
        f[FLAG_GTE]  = ge;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                end else begin
                    logic [7:0] ef;
                    int         ec;
                    ef = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("flags", {24'd0, dut_flags()}, {24'd0, ef});
                    check("done_cycle", cyc, ec);
                end
            end
        end
    end

    // Driver: one comparison; stall_len idle cycles inserted before bit index stall_at.
    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [7:0] ef, input int stall_at, input int stall_len,
                           input bit mid_start);
        int guard;
        @(posedge clk); #1;
        guard = 0;
        while (busy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 50 cycles");
        end
        start = 1'b1;
        exp_q.push_back(ef);
        exp_cyc_q.push_back(cyc + WIDTH + 1 + stall_len);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (k == stall_at) begin
                bit_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_ready", {31'd0, bit_ready}, 32'd1);
                    @(posedge clk); #1;
                end
            end
            bit_valid = 1'b1;
            a_bit     = a[WIDTH-1-k];
            b_bit     = b[WIDTH-1-k];
            start     = mid_start;
            @(posedge clk); #1;
            start = 1'b0;
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst_bit_ready", {31'd0, bit_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_flags", {24'd0, dut_flags()}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        @(posedge clk); #1;
        rst_n = 1'b1;

        //          a      b      eq ne ce cne lt gt le ge
        run_cmp(4'd9,  4'd9,  mk(1, 0, 1, 0, 0, 0, 1, 1), -1, 0, 0);
        run_cmp(4'd3,  4'd12, mk(0, 1, 0, 1, 1, 0, 1, 0), -1, 0, 0);
`ifdef SERIAL_REL_SIGNED_CMP_EN
        run_cmp(4'd9,  4'd3,  mk(0, 1, 0, 1, 1, 0, 1, 0), -1, 0, 0);
        run_cmp(4'd0,  4'd15, mk(0, 1, 0, 1, 0, 1, 0, 1), -1, 0, 0);
`else
        run_cmp(4'd9,  4'd3,  mk(0, 1, 0, 1, 0, 1, 0, 1), -1, 0, 0);
        run_cmp(4'd0,  4'd15, mk(0, 1, 0, 1, 1, 0, 1, 0), -1, 0, 0);
`endif
        run_cmp(4'd15, 4'd15, mk(1, 0, 1, 0, 0, 0, 1, 1), -1, 0, 0);
        run_cmp(4'd1,  4'd0,  mk(0, 1, 0, 1, 0, 1, 0, 1), -1, 0, 0);
        // Stall three cycles after the second bit.
        run_cmp(4'd5,  4'd6,  mk(0, 1, 0, 1, 1, 0, 1, 0), 2, 3, 0);
        // start held during SHIFT must not restart or consume bits.
        run_cmp(4'd12, 4'd10, mk(0, 1, 0, 1, 0, 1, 0, 1), -1, 0, 1);

        // Reset mid-comparison after two bits.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit_valid = 1'b1;
            a_bit     = k[0];
            b_bit     = ~k[0];
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_bit_ready", {31'd0, bit_ready}, 32'd0);
        check("mid_rst_flags", {24'd0, dut_flags()}, 32'd0);
        repeat (3) begin
            a_bit = $urandom_range(0, 1);
            b_bit = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Recovery after reset.
        run_cmp(4'd6,  4'd6,  mk(1, 0, 1, 0, 0, 0, 1, 1), -1, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("pending_done", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
